// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI DAC master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  // SPI mode encodings as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int spi_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK divider: toggles sck every CLK_DIV clk cycles while enabled and flags
// which kind of edge (leading/trailing) the coming toggle produces.
module spi_clk_gen #(
  parameter int CLK_DIV = 5,
  parameter bit CPOL    = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_tgl_en,
  output logic o_tick,
  output logic o_sck,
  output logic o_lead_stb,
  output logic o_trail_stb
);
  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic [DIV_W-1:0] r_div;
  logic             r_sck;
  logic             w_wrap;

  assign w_wrap = (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en) begin
      r_div <= '0;
      r_sck <= CPOL;
    end else begin
      r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
      if (w_wrap && i_tgl_en) r_sck <= ~r_sck;
    end
  end

  // Strobes fire in the cycle before the edge becomes visible on sck
  assign o_tick      = i_en & w_wrap;
  assign o_lead_stb  = o_tick & i_tgl_en & (r_sck == CPOL);
  assign o_trail_stb = o_tick & i_tgl_en & (r_sck != CPOL);
  assign o_sck       = r_sck;

endmodule

// File: rtl/spi_dac_master.sv
// Write-only SPI master for DAC pins: valid/ready frame in, sck/mosi/cs_n out.
// Optional DAC load strobe (ldac_n) enabled by defining SPI_DAC_LDAC_EN.
module spi_dac_master
  import spi_pkg::*;
#(
  parameter int FRAME_W   = 16,
  parameter int CLK_DIV   = 5,
  parameter int N_CS      = 2,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CS_GAP    = 2,
  localparam int SEL_W    = spi_sel_w(N_CS)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tx_valid,
  output logic               o_tx_ready,
  input  logic [FRAME_W-1:0] i_tx_data,
  input  logic [SEL_W-1:0]   i_tx_cs_sel,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_sck,
  output logic               o_mosi,
  output logic [N_CS-1:0]    o_cs_n
`ifdef SPI_DAC_LDAC_EN
  ,
  output logic               o_ldac_n
`endif
);
  localparam int         EDGE_W      = $clog2(2 * FRAME_W + 1);
  localparam logic [1:0] SPI_MODE    = {CPOL, CPHA};
  localparam bit         ADV_ON_LEAD = !((SPI_MODE == MODE0) || (SPI_MODE == MODE2));
`ifdef SPI_DAC_LDAC_EN
  // Stretch the gap so ldac_n is back high before the next cs_n fall
  localparam int GAP_LEN = (CS_GAP > CLK_DIV + 1) ? CS_GAP : CLK_DIV + 1;
`else
  localparam int GAP_LEN = CS_GAP;
`endif

  spi_state_e         r_state, w_next;
  logic [FRAME_W-1:0] r_sh;
  logic [SEL_W-1:0]   r_sel;
  logic [EDGE_W-1:0]  r_edge;
  logic [GAP_LEN-1:0] r_gap;
  logic               r_rdy, r_mosi, r_done;
  logic               w_hs, w_sel_ok, w_en, w_tgl_en;
  logic               w_tick, w_lead, w_trail, w_last, w_adv;

  function automatic logic first_bit(input logic [FRAME_W-1:0] d);
    return MSB_FIRST ? d[FRAME_W-1] : d[0];
  endfunction

  function automatic logic [FRAME_W-1:0] shift_out(input logic [FRAME_W-1:0] d);
    return MSB_FIRST ? {d[FRAME_W-2:0], 1'b0} : {1'b0, d[FRAME_W-1:1]};
  endfunction

  assign w_hs     = i_tx_valid & r_rdy;
  assign w_sel_ok = (int'(i_tx_cs_sel) < N_CS);
  assign w_en     = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
  assign w_tgl_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
  assign w_last   = (r_edge == EDGE_W'(2 * FRAME_W - 1));
  // CPHA=0 never advances on the final trailing edge so mosi holds the last bit
  assign w_adv    = ADV_ON_LEAD ? w_lead : (w_trail & ~w_last);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (w_en),
    .i_tgl_en    (w_tgl_en),
    .o_tick      (w_tick),
    .o_sck       (o_sck),
    .o_lead_stb  (w_lead),
    .o_trail_stb (w_trail)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_cs_n = '1;
    if (w_en) o_cs_n[r_sel] = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_hs && w_sel_ok) w_next = ST_SETUP;
      ST_SETUP: if (w_tick) w_next = ST_SHIFT;
      ST_SHIFT: if (w_tick && w_last) w_next = ST_HOLD;
      ST_HOLD:  if (w_tick) w_next = ST_GAP;
      ST_GAP:   if (r_gap[GAP_LEN-1]) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdy  <= 1'b0;
      r_done <= 1'b0;
      r_mosi <= 1'b0;
      r_sh   <= '0;
      r_sel  <= '0;
      r_edge <= '0;
      r_gap  <= '0;
    end else begin
      r_rdy  <= (w_next == ST_IDLE);
      r_done <= (r_state == ST_HOLD) && w_tick;
      if (r_state == ST_IDLE && w_hs && w_sel_ok) begin
        r_sel  <= i_tx_cs_sel;
        r_edge <= '0;
        if (ADV_ON_LEAD) begin
          r_sh <= i_tx_data;
        end else begin
          r_mosi <= first_bit(i_tx_data);
          r_sh   <= shift_out(i_tx_data);
        end
      end
      if (w_adv) begin
        r_mosi <= first_bit(r_sh);
        r_sh   <= shift_out(r_sh);
      end
      if (w_lead || w_trail) r_edge <= r_edge + EDGE_W'(1);
      // One-hot gap timer: bit k set during the k-th GAP cycle
      if (r_state == ST_HOLD && w_tick) begin
        r_mosi <= 1'b0;
        r_gap  <= GAP_LEN'(1);
      end else if (r_state == ST_GAP) begin
        r_gap <= r_gap << 1;
      end
    end
  end

  assign o_tx_ready = r_rdy;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_mosi     = r_mosi;

`ifdef SPI_DAC_LDAC_EN
  assign o_ldac_n = ~((r_state == ST_GAP) && (|r_gap[CLK_DIV:1]));
`endif

endmodule

// File: tb/tb_spi_dac_master.sv
// Scoreboard bench: two DUTs (mode 0 MSB-first, mode 3 LSB-first); frames are
// queued at handshake and compared against bits captured on rising sck edges.
module tb_spi_dac_master;
  localparam int FW  = 16;
  localparam int DIV = 5;
`ifdef SPI_DAC_LDAC_EN
  localparam int GAP = 6;
`else
  localparam int GAP = 2;
`endif
  localparam int DONE_OFF = 1 + (2 * FW + 1) * DIV;  // 166
  localparam int PERIOD   = DONE_OFF + GAP;          // handshake to next ready

  logic clk = 1'b0, rst_n = 1'b0;
  int   cyc = 0, n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: mode 0, MSB first, 3 chip selects (so an out-of-range select exists)
  logic        a_valid, a_ready, a_busy, a_done, a_sck, a_mosi, a_ldac_n;
  logic [15:0] a_data;
  logic [1:0]  a_sel;
  logic [2:0]  a_cs_n;
  // DUT B: CPOL=1, CPHA=1, LSB first, 2 chip selects
  logic        b_valid, b_ready, b_busy, b_done, b_sck, b_mosi, b_ldac_n;
  logic [15:0] b_data;
  logic        b_sel;
  logic [1:0]  b_cs_n;

  spi_dac_master #(.FRAME_W(FW), .CLK_DIV(DIV), .N_CS(3), .CPOL(1'b0), .CPHA(1'b0),
                   .MSB_FIRST(1'b1), .CS_GAP(2)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(a_valid), .o_tx_ready(a_ready),
    .i_tx_data(a_data), .i_tx_cs_sel(a_sel), .o_busy(a_busy), .o_done(a_done),
    .o_sck(a_sck), .o_mosi(a_mosi), .o_cs_n(a_cs_n)
`ifdef SPI_DAC_LDAC_EN
    , .o_ldac_n(a_ldac_n)
`endif
  );

  spi_dac_master #(.FRAME_W(FW), .CLK_DIV(DIV), .N_CS(2), .CPOL(1'b1), .CPHA(1'b1),
                   .MSB_FIRST(1'b0), .CS_GAP(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(b_valid), .o_tx_ready(b_ready),
    .i_tx_data(b_data), .i_tx_cs_sel(b_sel), .o_busy(b_busy), .o_done(b_done),
    .o_sck(b_sck), .o_mosi(b_mosi), .o_cs_n(b_cs_n)
`ifdef SPI_DAC_LDAC_EN
    , .o_ldac_n(b_ldac_n)
`endif
  );

`ifndef SPI_DAC_LDAC_EN
  assign a_ldac_n = 1'b1;
  assign b_ldac_n = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // ---------------- monitors / scoreboards ----------------
  logic [15:0] a_q[$], b_q[$];
  logic [15:0] a_rx, b_rx;
  logic        a_psck, b_psck;
  int a_nrise, a_rise1, a_done_cyc, a_tot_rise = 0, a_tot_done = 0, a_hi_run;
  int b_nrise;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_rx = '0; a_nrise = 0; a_psck = 1'b0; a_hi_run = 1000;
    end else begin
      if (!a_psck && a_sck) begin
        a_rx = {a_rx[14:0], a_mosi};
        a_nrise++; a_tot_rise++;
        if (a_nrise == 1) a_rise1 = cyc;
      end
      a_psck = a_sck;
      chk("a_cs_onehot", $countones(~a_cs_n) <= 1, 1);
      if (a_cs_n == 3'b111) a_hi_run++;
      else begin
        if (a_hi_run > 0) chk("a_cs_gap", a_hi_run >= GAP, 1);
        a_hi_run = 0;
      end
      if (a_done) begin
        a_tot_done++; a_done_cyc = cyc;
        chk("a_q_has_entry", a_q.size() != 0, 1);
        if (a_q.size() != 0) chk("a_frame", a_rx, a_q.pop_front());
        chk("a_nrise", a_nrise, FW);
        a_rx = '0; a_nrise = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_rx = '0; b_nrise = 0; b_psck = 1'b1;
    end else begin
      if (!b_psck && b_sck) begin
        b_rx = {b_mosi, b_rx[15:1]};
        b_nrise++;
      end
      b_psck = b_sck;
      if (b_done) begin
        chk("b_q_has_entry", b_q.size() != 0, 1);
        if (b_q.size() != 0) chk("b_frame", b_rx, b_q.pop_front());
        chk("b_nrise", b_nrise, FW);
        chk("b_sck_end", b_sck, 1);
        b_rx = '0; b_nrise = 0;
      end
    end
  end

  // Handshake on A; returns at the negedge of T0+1 with inputs perturbed
  task automatic send_a(input logic [15:0] d, input logic [1:0] s, input bit keep,
                        output int t0);
    int n = 0;
    a_data = d; a_sel = s; a_valid = 1'b1;
    while (!a_ready && n < 1000) begin @(negedge clk); n++; end
    chk("a_hs_timeout", n < 1000, 1);
    t0 = cyc;
    if (s < 2'd3) a_q.push_back(d);
    @(negedge clk);
    a_data = ~d; a_sel = ~s;
    if (!keep) a_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, nr, nd;
    a_valid = 0; a_data = '0; a_sel = '0;
    b_valid = 0; b_data = '0; b_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", a_cs_n, 3'b111);
    chk("rst_sck_a", a_sck, 0);
    chk("rst_sck_b", b_sck, 1);
    chk("rst_mosi", a_mosi, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ldac", a_ldac_n, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", a_ready, 1);

    // Mode 0 single frame with exact timing
    send_a(16'h0C78, 2'd0, 1'b0, t0);
    chk("t1_cs_setup", a_cs_n, 3'b110);
    chk("t1_busy", a_busy, 1);
    chk("t1_ready_low", a_ready, 0);
    at(t0 + DONE_OFF - 1);
    chk("t1_cs_hold", a_cs_n, 3'b110);
    chk("t1_done_early", a_done, 0);
    at(t0 + DONE_OFF);
    chk("t1_cs_rise", a_cs_n, 3'b111);
    chk("t1_done", a_done, 1);
    chk("t1_mosi_gap", a_mosi, 0);
    chk("t1_ldac_pre", a_ldac_n, 1);
`ifdef SPI_DAC_LDAC_EN
    at(t0 + DONE_OFF + 1);   chk("t1_ldac_lo0", a_ldac_n, 0);
    at(t0 + DONE_OFF + DIV); chk("t1_ldac_lo4", a_ldac_n, 0);
    at(t0 + DONE_OFF + DIV + 1); chk("t1_ldac_hi", a_ldac_n, 1);
`endif
    at(t0 + PERIOD - 1);
    chk("t1_ready_gap", a_ready, 0);
    at(t0 + PERIOD);
    chk("t1_ready", a_ready, 1);
    chk("t1_rise1", a_rise1, t0 + 1 + DIV);
    chk("t1_done_cyc", a_done_cyc, t0 + DONE_OFF);

    // Mode 3, LSB first on DUT B
    begin
      int n = 0;
      b_data = 16'hA501; b_sel = 1'b1; b_valid = 1'b1;
      while (!b_ready && n < 1000) begin @(negedge clk); n++; end
      chk("b_hs_timeout", n < 1000, 1);
      t0 = cyc; b_q.push_back(16'hA501);
      chk("b_sck_idle", b_sck, 1);
      @(negedge clk);
      b_valid = 1'b0; b_data = 16'h0000; b_sel = 1'b0;
      chk("b_cs_setup", b_cs_n, 2'b01);
      at(t0 + PERIOD);
      chk("b_sck_after", b_sck, 1);
      chk("b_ready", b_ready, 1);
    end

    // Back-to-back frames with tx_valid held
    send_a(16'h1234, 2'd1, 1'b1, t0);
    send_a(16'hBEEF, 2'd0, 1'b1, t1);
    send_a(16'h8001, 2'd1, 1'b0, t2);
    chk("b2b_gap01", t1 - t0, PERIOD);
    chk("b2b_gap12", t2 - t1, PERIOD);
    at(t2 + PERIOD);

    // Out-of-range select: consumed silently
    nr = a_tot_rise; nd = a_tot_done;
    send_a(16'hFFFF, 2'd3, 1'b0, t0);
    chk("bad_ready", a_ready, 1);
    chk("bad_busy", a_busy, 0);
    chk("bad_cs", a_cs_n, 3'b111);
    at(t0 + 200);
    chk("bad_rises", a_tot_rise, nr);
    chk("bad_dones", a_tot_done, nd);
    chk("bad_mosi", a_mosi, 0);

    // Reset in the middle of a frame
    send_a(16'h5A3C, 2'd2, 1'b0, t0);
    chk("mid_cs_setup", a_cs_n, 3'b011);
    nd = a_tot_done;
    at(t0 + 80);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cs", a_cs_n, 3'b111);
    chk("mid_rst_sck", a_sck, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_done", a_done, 0);
    a_q.delete();
    rst_n = 1'b1;
    at(t0 + 300);
    chk("mid_no_done", a_tot_done, nd);
    send_a(16'h9C3E, 2'd2, 1'b0, t1);
    at(t1 + PERIOD);
    chk("mid_after_done", a_tot_done, nd + 1);

    chk("a_q_drain", a_q.size(), 0);
    chk("b_q_drain", b_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
